spi_txn_arbiter: RTL
====================

Name: spi_txn_arbiter

Overview:
- Sequences multi-byte SPI transactions on a single spi_master byte engine and shares it between two requesters.
- Arbitrates round-robin and latches the transaction length at grant.
- Drives a per-requester active-low chip select with programmable setup and hold gaps.
- Streams TX bytes from the granted requester into the engine and routes RX bytes back to that requester only.
- Sits between the spi_master byte interface and client blocks such as a flash reader and a register poller.

Parameters:
- LEN_W, 4, width of the length field; a transaction carries len_i+1 bytes (1..2^LEN_W).
- CS_DELAY, 4, clk_i cycles that cs_n is held low before the first byte (setup) and after the last RX byte (hold); legal range 1..255.

Ports:
- clk_i  input  1  system clock.
- reset_i  input  1  asynchronous, active-high reset.
- req_i  input  2  per-requester transaction request, level; bit 0 = requester 0.
- len_i  input  2*LEN_W  per-requester byte count minus 1; requester n uses bits [n*LEN_W +: LEN_W].
- tx_byte_i  input  16  per-requester TX byte; requester n uses bits [n*8 +: 8].
- tx_valid_i  input  2  per-requester TX byte valid.
- tx_ready_o  output  2  per-requester TX byte accepted this cycle.
- rx_byte_o  output  8  RX byte, shared by both requesters.
- rx_valid_o  output  2  one-hot RX strobe to the owning requester.
- done_o  output  2  one-cycle pulse when a requester's transaction completes.
- busy_o  output  1  high in any state other than IDLE.
- cs_n_o  output  2  active-low chip select per requester.
- m_tx_byte_o  output  8  byte to spi_master.
- m_tx_valid_o  output  1  byte valid to spi_master.
- m_tx_ready_i  input  1  spi_master ready for a byte.
- m_rx_byte_i  input  8  byte from spi_master.
- m_rx_valid_i  input  1  spi_master RX strobe.

Behaviour:
- Reset values:
  - cs_n_o = 2'b11.
  - tx_ready_o, rx_valid_o, done_o = 0; m_tx_valid_o = 0; busy_o = 0.
  - m_tx_byte_o and rx_byte_o = 8'h00.
  - State = IDLE; round-robin pointer last_grant = 1, so requester 0 wins the first tie.
- States and transitions:
  - IDLE: if any req_i bit is set, grant and go to SETUP.
    - One requester: grant that requester.
    - Both requesters: grant the one not equal to last_grant.
    - On grant: latch gnt and len_i[gnt]; set last_grant = gnt; clear counters.
  - SETUP: cs_n_o[gnt] = 0. After CS_DELAY cycles (counter from 0 to CS_DELAY-1), go to XFER.
  - XFER: a byte is sent when m_tx_valid_o && m_tx_ready_i.
    - m_tx_valid_o = tx_valid_i[gnt] && (tx_cnt <= len_q).
    - m_tx_byte_o = tx_byte_i[gnt], combinational pass-through.
    - tx_ready_o[gnt] = m_tx_ready_i && (tx_cnt <= len_q); tx_ready_o is always 0 for the non-granted requester.
    - tx_cnt increments on each send.
    - Each m_rx_valid_i increments rx_cnt.
    - When the RX strobe for byte len_q arrives, go to HOLD.
  - HOLD: cs_n_o[gnt] stays low for CS_DELAY cycles, then goes to DONE.
  - DONE (1 cycle): cs_n_o = 2'b11; done_o[gnt] = 1; return to IDLE.
  - cs_n is high for at least 2 cycles (DONE plus IDLE) between consecutive transactions.
- RX routing:
  - rx_byte_o is registered from m_rx_byte_i.
  - rx_valid_o[gnt] is a registered copy of m_rx_valid_i (1-cycle latency), only while the state is XFER.
  - An m_rx_valid_i outside XFER is dropped.
- Counter widths: tx_cnt and rx_cnt are LEN_W+1 bits so that len = 2^LEN_W-1 does not wrap.
- Requester stall: if tx_valid_i[gnt] is low in XFER, m_tx_valid_o stays low and the engine idles. There is no timeout; cs_n stays asserted.
- Dropping req_i mid-transaction: ignored; the latched length completes.
- Changing len_i after grant: no effect on the current transaction.
- Request held after done: req_i still high after done_o re-arbitrates in IDLE. With both requesting continuously, grants alternate 0, 1, 0, 1.
- Only one chip select is ever low; cs_n_o == 2'b00 is illegal.
- Reset mid-operation: cs_n_o goes to 2'b11 immediately (asynchronous), and all strobes clear. The block does not attempt to complete the partial transfer.

Test Plan:
- Single transaction: req_i=01, len=2 (3 bytes), TX 8'hA1,8'hB2,8'hC3, spi_master model echoes bytes.
  -> cs_n_o[0] low CS_DELAY cycles before the first m_tx_valid_o.
  -> rx_valid_o=01 exactly 3 times with A1,B2,C3.
  -> cs_n_o[0] high CS_DELAY+1 cycles after the third RX strobe; done_o=01 for one cycle.
- Contention: req_i=11 from reset, both len=0.
  -> requester 0 served first, then requester 1.
  -> cs_n_o never 00.
  -> done_o sequence 01 then 10; cs_n_o high at least 2 cycles between transactions.
- Fairness: both requesters held high for 6 transactions -> grant order 0,1,0,1,0,1.
- Stall: tx_valid_i[1] deasserted for 20 cycles mid-transfer of len=3.
  -> m_tx_valid_o low during the stall; cs_n_o[1] stays low.
  -> all 4 bytes complete afterwards.
- Maximum length: LEN_W=4, len=15.
  -> exactly 16 m_tx handshakes and 16 rx_valid_o strobes, no counter wrap.
- Reset mid-XFER: reset_i pulsed after 2 of 4 bytes.
  -> cs_n_o=11 and busy_o=0 asynchronously.
  -> after release, a fresh req_i=10 is granted to requester 1 (last_grant reset to 1, sole requester).

Source files
------------

// File: rtl/spi_txn_arbiter.sv
// Shares one spi_master byte engine between two requesters: round-robin grant,
// per-requester chip select with setup/hold gaps, TX streaming and RX routing.
module spi_txn_arbiter #(
  parameter int unsigned LEN_W    = 4,
  parameter int unsigned CS_DELAY = 4
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [1:0]           req_i,
  input  logic [2*LEN_W-1:0]   len_i,
  input  logic [15:0]          tx_byte_i,
  input  logic [1:0]           tx_valid_i,
  output logic [1:0]           tx_ready_o,
  output logic [7:0]           rx_byte_o,
  output logic [1:0]           rx_valid_o,
  output logic [1:0]           done_o,
  output logic                 busy_o,
  output logic [1:0]           cs_n_o,
  output logic [7:0]           m_tx_byte_o,
  output logic                 m_tx_valid_o,
  input  logic                 m_tx_ready_i,
  input  logic [7:0]           m_rx_byte_i,
  input  logic                 m_rx_valid_i
);

  localparam int unsigned CNT_W = LEN_W + 1;
  localparam int unsigned DLY_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_XFER  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic               gnt_q, gnt_d, last_grant_q;
  logic [LEN_W-1:0]   len_q;
  logic [CNT_W-1:0]   tx_cnt_q, rx_cnt_q;
  logic [DLY_W-1:0]   dly_cnt_q;
  logic               tx_open, tx_fire, rx_last, dly_last;

  // Round-robin pick: a sole requester wins, a tie goes to the one not served last
  always_comb begin
    gnt_d = 1'b0;
    unique case (req_i)
      2'b10:   gnt_d = 1'b1;
      2'b11:   gnt_d = ~last_grant_q;
      default: gnt_d = 1'b0;
    endcase
  end

  assign tx_open  = (tx_cnt_q <= CNT_W'(len_q));
  assign tx_fire  = m_tx_valid_o & m_tx_ready_i;
  assign rx_last  = m_rx_valid_i & (rx_cnt_q == CNT_W'(len_q));
  assign dly_last = (dly_cnt_q == DLY_W'(CS_DELAY - 1));

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (|req_i)   state_d = ST_SETUP;
      ST_SETUP: if (dly_last) state_d = ST_XFER;
      ST_XFER:  if (rx_last)  state_d = ST_HOLD;
      ST_HOLD:  if (dly_last) state_d = ST_DONE;
      ST_DONE:                state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cs_n_o       = 2'b11;
    tx_ready_o   = 2'b00;
    done_o       = 2'b00;
    m_tx_valid_o = 1'b0;
    m_tx_byte_o  = 8'h00;
    busy_o       = (state_q != ST_IDLE);
    unique case (state_q)
      ST_SETUP, ST_HOLD: cs_n_o[gnt_q] = 1'b0;
      ST_XFER: begin
        cs_n_o[gnt_q]     = 1'b0;
        m_tx_valid_o      = tx_valid_i[gnt_q] & tx_open;
        m_tx_byte_o       = gnt_q ? tx_byte_i[15:8] : tx_byte_i[7:0];
        tx_ready_o[gnt_q] = m_tx_ready_i & tx_open;
      end
      ST_DONE: done_o[gnt_q] = 1'b1;
      default: ;
    endcase
  end

  // Grant/length latch, byte counters and gap timer
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      gnt_q        <= 1'b0;
      last_grant_q <= 1'b1;
      len_q        <= '0;
      tx_cnt_q     <= '0;
      rx_cnt_q     <= '0;
      dly_cnt_q    <= '0;
    end else begin
      if (state_q == ST_IDLE && (|req_i)) begin
        gnt_q        <= gnt_d;
        last_grant_q <= gnt_d;
        len_q        <= gnt_d ? len_i[2*LEN_W-1:LEN_W] : len_i[LEN_W-1:0];
        tx_cnt_q     <= '0;
        rx_cnt_q     <= '0;
      end
      if (state_q == ST_XFER) begin
        if (tx_fire)      tx_cnt_q <= tx_cnt_q + CNT_W'(1);
        if (m_rx_valid_i) rx_cnt_q <= rx_cnt_q + CNT_W'(1);
      end
      if (state_d == state_q && (state_q == ST_SETUP || state_q == ST_HOLD))
        dly_cnt_q <= dly_cnt_q + DLY_W'(1);
      else
        dly_cnt_q <= '0;
    end
  end

  // RX bytes go back only to the owner, and only while bytes are in flight
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rx_byte_o  <= 8'h00;
      rx_valid_o <= 2'b00;
    end else begin
      rx_byte_o  <= m_rx_byte_i;
      rx_valid_o <= 2'b00;
      if (state_q == ST_XFER && m_rx_valid_i) rx_valid_o[gnt_q] <= 1'b1;
    end
  end

endmodule
